freq_select_sequencer: RTL and testbench
========================================

Name: freq_select_sequencer

Overview:
Configuration scheduler for a bank of per-channel freq_gen oscillators. It turns frequency-step events, tick pulses and a pattern mode into per-channel set/select writes. Writes are issued one channel per cycle as a sweep. The block sits between the debounced button logic / tick generator and the LED oscillator bank's set_i/select_i ports.

Parameters:
WIDTH, 8, number of oscillator channels (>=2)
FREQ_STEPS, 16, number of selectable frequency steps per channel (>=2)
INIT_STEP, 0, reset value of the base step and of every select slice (<FREQ_STEPS)
SEL_WIDTH, $clog2(FREQ_STEPS), derived localparam, width of one select slice

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous active-low reset
en_i  in  1  sequencer enable
tick_i  in  1  single-cycle tick pulse, advances the chase phase
mode_i  in  2  pattern: 00 hold, 01 ramp-up, 10 ramp-down, 11 chase
step_up_i  in  1  single-cycle pulse, base step +1
step_dwn_i  in  1  single-cycle pulse, base step -1
set_o  out  WIDTH  per-channel single-cycle load strobe
select_o  out  WIDTH*SEL_WIDTH  packed select values; channel k is slice [k*SEL_WIDTH +: SEL_WIDTH]
busy_o  out  1  sweep in progress
base_o  out  SEL_WIDTH  current base step

Behaviour:
- Reset values: base=INIT_STEP, phase=0, set_o=0, every select_o slice=INIT_STEP, busy_o=0, pending=0, FSM=IDLE, en_q=0, mode_q=00.
- Base step update (every cycle while en_i=1):
  - step_up_i alone: +1, saturating at FREQ_STEPS-1.
  - step_dwn_i alone: -1, saturating at 0.
  - Both high together: ignored, no event.
  - A saturated step (no value change) raises no event.
- Phase update: tick_i with mode_i=11 advances phase 0..WIDTH-1, wrapping WIDTH-1 -> 0. Other modes leave phase unchanged.
- Events that set pending:
  - Base value change.
  - Phase change.
  - mode_i differing from mode_q; mode_q then updates.
  - en_i rising edge (en_i=1, en_q=0), including en_i already high at reset release.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP when pending=1 and en_i=1. On that edge: clear pending, snapshot base/mode/phase, idx=0.
  - SWEEP: on each edge, drive set_o = one-hot(idx), write select slice idx, then idx+1.
  - After writing idx=WIDTH-1: set_o=0 on the next edge, return to IDLE.
- Sweep timing:
  - Event captured at edge E.
  - set_o[k] is high in the cycle following edge E+1+k, with slice k valid in the same cycle and held afterwards.
  - busy_o is high for exactly WIDTH cycles.
- Slice value for channel k, computed from snapshot values:
  - hold: base.
  - ramp-up: min(base+k, FREQ_STEPS-1), computed with SEL_WIDTH+$clog2(WIDTH)+1 bits.
  - ramp-down: base>=k ? base-k : 0.
  - chase: k==phase ? base : 0.
- Events during SWEEP:
  - They set pending (one-deep, coalesced). The in-flight sweep is never altered.
  - After the sweep: one IDLE cycle, then a new sweep using the latest values.
  - An event on the final SWEEP edge is still captured.
- en_i low:
  - Next edge: FSM=IDLE, set_o=0, busy_o=0, pending=0, phase=0.
  - base and select_o are retained; step pulses are ignored.
  - A partial sweep is abandoned; written slices keep their new values.
- base_o: registered, reflects base one cycle after the step pulse.
- Mid-operation reset: returns immediately to reset values.

Test Plan:
- Reset with en_i=1, WIDTH=8, mode=00, INIT_STEP=0:
  - -> sweep starts automatically; set_o walks 0x01..0x80 on 8 consecutive cycles; all slices=0; busy_o high 8 cycles.
- mode=01, base=0, then 3 step_up_i pulses spaced 20 cycles:
  - -> base_o=3; final sweep slices = 3,4,5,...,10; base never exceeds 15 after 20 further pulses.
  - -> final ramp slices saturate at 15.
- mode=10, base=2, sweep completes:
  - -> slices = 2,1,0,0,0,0,0,0.
  - A step_dwn_i at base=0 -> no sweep (busy_o stays 0).
- mode=11, base=5, nine tick_i pulses spaced 20 cycles:
  - -> phase sequence 1..7,0,1.
  - -> after each sweep exactly one slice=5 at channel phase, others 0.
- step_up_i pulsed twice during an active sweep:
  - -> current sweep finishes with old base; one IDLE cycle; exactly one more sweep with base+2.
  - step_up_i and step_dwn_i in the same cycle -> no change, no sweep.
- en_i dropped mid-sweep at idx=3:
  - -> set_o=0 next cycle; slices 0..2 new, 3..7 old.
  - en_i re-raised -> full 8-channel sweep; arstn_i low mid-sweep -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/freq_select_sequencer.sv
// Sweeps per-channel oscillator select values one channel per cycle whenever the
// base step, chase phase, pattern mode or enable changes.
module freq_select_sequencer #(
    parameter int WIDTH      = 8,
    parameter int FREQ_STEPS = 16,
    parameter int INIT_STEP  = 0,
    localparam int SEL_WIDTH = $clog2(FREQ_STEPS)
) (
    input  logic                         clk_i,
    input  logic                         arstn_i,
    input  logic                         en_i,
    input  logic                         tick_i,
    input  logic [1:0]                   mode_i,
    input  logic                         step_up_i,
    input  logic                         step_dwn_i,
    output logic [WIDTH-1:0]             set_o,
    output logic [WIDTH*SEL_WIDTH-1:0]   select_o,
    output logic                         busy_o,
    output logic [SEL_WIDTH-1:0]         base_o
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CW    = IDX_W + 1;                 // idx counts to WIDTH
    localparam int RW    = SEL_WIDTH + IDX_W + 1;
    localparam logic [SEL_WIDTH-1:0] MAX_STEP  = SEL_WIDTH'(FREQ_STEPS - 1);
    localparam logic [SEL_WIDTH-1:0] INIT_SEL  = SEL_WIDTH'(INIT_STEP);

    typedef enum logic [0:0] {IDLE, SWEEP} state_t;

    state_t                       state_q, state_d;
    logic [SEL_WIDTH-1:0]         base_q, base_d;
    logic [IDX_W-1:0]             phase_q, phase_d;
    logic                         pending_q, pending_d;
    logic                         en_q;
    logic [1:0]                   mode_q;
    logic [SEL_WIDTH-1:0]         snap_base_q, snap_base_d;
    logic [1:0]                   snap_mode_q, snap_mode_d;
    logic [IDX_W-1:0]             snap_phase_q, snap_phase_d;
    logic [CW-1:0]                idx_q, idx_d;
    logic [WIDTH-1:0]             set_q, set_d;
    logic [WIDTH*SEL_WIDTH-1:0]   sel_q, sel_d;
    logic                         ev;

    function automatic logic [SEL_WIDTH-1:0] slice_f(input logic [SEL_WIDTH-1:0] b,
                                                     input logic [1:0]           m,
                                                     input logic [IDX_W-1:0]     p,
                                                     input logic [CW-1:0]        k);
        logic [RW-1:0] sum;
        sum = RW'(b) + RW'(k);
        case (m)
            2'b00:   slice_f = b;
            2'b01:   slice_f = (sum > RW'(FREQ_STEPS - 1)) ? MAX_STEP : sum[SEL_WIDTH-1:0];
            2'b10:   slice_f = (RW'(b) >= RW'(k)) ? SEL_WIDTH'(RW'(b) - RW'(k)) : '0;
            default: slice_f = (k == CW'(p)) ? b : '0;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        phase_d      = phase_q;
        pending_d    = pending_q;
        idx_d        = idx_q;
        snap_base_d  = snap_base_q;
        snap_mode_d  = snap_mode_q;
        snap_phase_d = snap_phase_q;
        set_d        = '0;
        sel_d        = sel_q;
        ev           = 1'b0;
        if (!en_i) begin
            state_d   = IDLE;
            pending_d = 1'b0;
            phase_d   = '0;
        end else begin
            if (step_up_i && !step_dwn_i && base_q != MAX_STEP) begin
                base_d = base_q + 1'b1;
                ev     = 1'b1;
            end
            if (step_dwn_i && !step_up_i && base_q != '0) begin
                base_d = base_q - 1'b1;
                ev     = 1'b1;
            end
            if (tick_i && mode_i == 2'b11) begin
                phase_d = (phase_q == IDX_W'(WIDTH - 1)) ? '0 : phase_q + 1'b1;
                ev      = 1'b1;
            end
            if (mode_i != mode_q || !en_q) ev = 1'b1;

            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        // Channel 0 is written on the start edge straight from the
                        // live registers, which equal the snapshot being taken.
                        state_d      = SWEEP;
                        pending_d    = 1'b0;
                        snap_base_d  = base_q;
                        snap_mode_d  = mode_q;
                        snap_phase_d = phase_q;
                        set_d[0]     = 1'b1;
                        sel_d[0 +: SEL_WIDTH] = slice_f(base_q, mode_q, phase_q, '0);
                        idx_d        = CW'(1);
                    end
                end
                SWEEP: begin
                    if (idx_q == CW'(WIDTH)) begin
                        state_d = IDLE;
                    end else begin
                        for (int k = 0; k < WIDTH; k++) begin
                            if (idx_q == CW'(k)) begin
                                set_d[k] = 1'b1;
                                sel_d[k*SEL_WIDTH +: SEL_WIDTH] =
                                    slice_f(snap_base_q, snap_mode_q, snap_phase_q, CW'(k));
                            end
                        end
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            // A new event always survives, even on the edge that starts a sweep.
            if (ev) pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q      <= IDLE;
            base_q       <= INIT_SEL;
            phase_q      <= '0;
            pending_q    <= 1'b0;
            en_q         <= 1'b0;
            mode_q       <= 2'b00;
            snap_base_q  <= INIT_SEL;
            snap_mode_q  <= 2'b00;
            snap_phase_q <= '0;
            idx_q        <= '0;
            set_q        <= '0;
            sel_q        <= {WIDTH{INIT_SEL}};
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            phase_q      <= phase_d;
            pending_q    <= pending_d;
            en_q         <= en_i;
            mode_q       <= mode_i;
            snap_base_q  <= snap_base_d;
            snap_mode_q  <= snap_mode_d;
            snap_phase_q <= snap_phase_d;
            idx_q        <= idx_d;
            set_q        <= set_d;
            sel_q        <= sel_d;
        end
    end

    assign set_o    = set_q;
    assign select_o = sel_q;
    assign busy_o   = (state_q == SWEEP);
    assign base_o   = base_q;

endmodule

// File: tb/tb_freq_select_sequencer.sv
// Directed bench for freq_select_sequencer: expected channel writes are queued
// when an event is driven and popped as set_o strobes appear.
module tb_freq_select_sequencer;

    localparam int W  = 8;
    localparam int FS = 16;
    localparam int SW = 4;

    logic            clk_i = 1'b0;
    logic            arstn_i;
    logic            en_i;
    logic            tick_i;
    logic [1:0]      mode_i;
    logic            step_up_i;
    logic            step_dwn_i;
    logic [W-1:0]    set_o;
    logic [W*SW-1:0] select_o;
    logic            busy_o;
    logic [SW-1:0]   base_o;

    typedef struct {
        int         ch;
        logic [3:0] val;
    } wr_t;

    wr_t sb[$];
    int  total = 0;
    int  bad = 0;
    int  busy_cnt = 0;
    int  mb = 0;
    int  mmode = 0;
    int  mphase = 0;

    freq_select_sequencer #(.WIDTH(W), .FREQ_STEPS(FS), .INIT_STEP(0)) dut (
        .clk_i(clk_i), .arstn_i(arstn_i), .en_i(en_i), .tick_i(tick_i), .mode_i(mode_i),
        .step_up_i(step_up_i), .step_dwn_i(step_dwn_i), .set_o(set_o),
        .select_o(select_o), .busy_o(busy_o), .base_o(base_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [3:0] ref_slice(input int b, input int m, input int p, input int k);
        int v;
        case (m)
            0:       v = b;
            1:       v = (b + k > FS - 1) ? FS - 1 : b + k;
            2:       v = (b - k < 0) ? 0 : b - k;
            default: v = (k == p) ? b : 0;
        endcase
        return 4'(v);
    endfunction

    function automatic logic [31:0] exp_vec(input int b, input int m, input int p);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < W; k++) v[k*SW +: SW] = ref_slice(b, m, p, k);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_sweep(input int b, input int m, input int p, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) sb.push_back('{k, ref_slice(b, m, p, k)});
    endtask

    task automatic mon();
        wr_t        e;
        logic [7:0] oh;
        if (busy_o) busy_cnt++;
        chk("busy_vs_set", 32'(busy_o), 32'(set_o != '0));
        if (set_o != '0) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                oh = 8'd1 << e.ch;
                chk("set_onehot", 32'(set_o), 32'(oh));
                chk("slice_val", 32'(select_o[e.ch*SW +: SW]), 32'(e.val));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        mon();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ev_step(input logic up, input logic dn, input logic tk, input logic [1:0] md);
        int changed;
        changed = 0;
        if (up && !dn && mb < FS - 1) begin mb++; changed = 1; end
        if (dn && !up && mb > 0) begin mb--; changed = 1; end
        if (tk && md == 2'b11) begin mphase = (mphase + 1) % W; changed = 1; end
        if (int'(md) != mmode) begin mmode = int'(md); changed = 1; end
        if (changed != 0) push_sweep(mb, mmode, mphase, 0, W - 1);
        busy_cnt   = 0;
        step_up_i  = up;
        step_dwn_i = dn;
        tick_i     = tk;
        mode_i     = md;
        tick();
        step_up_i  = 1'b0;
        step_dwn_i = 1'b0;
        tick_i     = 1'b0;
        chk("base_o", 32'(base_o), 32'(mb));
        repeat (19) tick();
        chk("busy_cycles", 32'(busy_cnt), (changed != 0) ? 32'd8 : 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] mixed;
        arstn_i = 1'b0; en_i = 1'b1; tick_i = 1'b0; mode_i = 2'b00;
        step_up_i = 1'b0; step_dwn_i = 1'b0;
        #1;
        chk("rst_set", 32'(set_o), 32'd0);
        chk("rst_sel", select_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_base", 32'(base_o), 32'd0);

        // Release with enable already high: automatic hold sweep of zeros.
        tick(); tick();
        arstn_i = 1'b1;
        push_sweep(0, 0, 0, 0, W - 1);
        busy_cnt = 0;
        repeat (20) tick();
        chk("auto_busy", 32'(busy_cnt), 32'd8);
        chk("auto_drained", 32'(sb.size()), 32'd0);

        // Ramp-up, then saturation.
        ev_step(0, 0, 0, 2'b01);
        repeat (3) ev_step(1, 0, 0, 2'b01);
        chk("base_3", 32'(base_o), 32'd3);
        chk("ramp_b3", select_o, 32'hA987_6543);
        repeat (20) ev_step(1, 0, 0, 2'b01);
        chk("base_sat", 32'(base_o), 32'd15);
        chk("ramp_sat", select_o, 32'hFFFF_FFFF);

        // Ramp-down to base 2, then floor.
        ev_step(0, 0, 0, 2'b10);
        repeat (13) ev_step(0, 1, 0, 2'b10);
        chk("rdown_b2", select_o, 32'h0000_0012);
        repeat (2) ev_step(0, 1, 0, 2'b10);
        ev_step(0, 1, 0, 2'b10);
        chk("floor_base", 32'(base_o), 32'd0);

        // Chase at base 5 through nine ticks.
        repeat (5) ev_step(1, 0, 0, 2'b10);
        ev_step(0, 0, 0, 2'b11);
        for (int t = 0; t < 9; t++) begin
            ev_step(0, 0, 1, 2'b11);
            chk("chase_vec", select_o, exp_vec(5, 3, mphase));
        end

        // Two step-ups during a sweep coalesce into one follow-up sweep.
        ev_step(0, 0, 0, 2'b01);
        mb = 6; push_sweep(6, 1, 0, 0, W - 1);
        mb = 8; push_sweep(8, 1, 0, 0, W - 1);
        step_up_i = 1'b1;
        tick();
        step_up_i = 1'b0;
        for (int j = 0; j < 20; j++) begin
            chk("burst_busy", 32'(busy_o), 32'((j >= 1 && j <= 8) || (j >= 10 && j <= 17)));
            step_up_i = (j == 2 || j == 4);
            tick();
        end
        step_up_i = 1'b0;
        chk("burst_drained", 32'(sb.size()), 32'd0);
        chk("burst_base", 32'(base_o), 32'd8);
        ev_step(1, 1, 0, 2'b01);

        // Enable dropped while channel 3 would be written.
        mb = 7;
        push_sweep(7, 1, 0, 0, 2);
        step_dwn_i = 1'b1;
        tick();
        step_dwn_i = 1'b0;
        tick(); tick(); tick();
        en_i = 1'b0;
        tick();
        mixed = '0;
        for (int k = 0; k < W; k++) mixed[k*SW +: SW] = (k < 3) ? ref_slice(7, 1, 0, k) : ref_slice(8, 1, 0, k);
        chk("abort_set", 32'(set_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_sel", select_o, mixed);
        chk("abort_drained", 32'(sb.size()), 32'd0);
        step_up_i = 1'b1;
        tick();
        step_up_i = 1'b0;
        tick();
        chk("dis_base", 32'(base_o), 32'd7);

        en_i = 1'b1;
        push_sweep(7, 1, 0, 0, W - 1);
        busy_cnt = 0;
        repeat (20) tick();
        chk("reen_busy", 32'(busy_cnt), 32'd8);
        chk("reen_drained", 32'(sb.size()), 32'd0);
        chk("reen_sel", select_o, exp_vec(7, 1, 0));

        // Asynchronous reset in the middle of a sweep.
        mb = 8;
        push_sweep(8, 1, 0, 0, 1);
        step_up_i = 1'b1;
        tick();
        step_up_i = 1'b0;
        tick(); tick();
        @(negedge clk_i);
        mon();
        #1 arstn_i = 1'b0;
        #1;
        chk("arst_set", 32'(set_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_sel", select_o, 32'd0);
        chk("arst_base", 32'(base_o), 32'd0);
        en_i = 1'b0;
        tick(); tick();
        arstn_i = 1'b1;
        repeat (5) tick();
        chk("end_drained", 32'(sb.size()), 32'd0);
        chk("end_busy", 32'(busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
